acc_sequencer: RTL and testbench

Control block for the double-buffered MMU output accumulator. It accepts tile commands (rows per pass, number of K passes), gates the MMU's per-pass streaming, and drives the accumulator's mode and buffer-select inputs. Pass 0 of a tile overwrites and later passes accumulate. After the final pass it publishes the filled buffer to a downstream reader and ping-pongs to the other buffer, stalling when both buffers hold unread results.

---
 rtl/acc_sequencer_if.sv | 28 ++
 rtl/acc_sequencer.sv | 122 ++++++++++++
 tb/tb_acc_sequencer.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/acc_sequencer_if.sv
// Command, MMU-gating, accumulator-control and read-side signals of the accumulator sequencer.
// master is the sequencer; slave is the command source / MMU / accumulator / reader side.
interface acc_sequencer_if #(
  parameter int unsigned ROW_W  = 8,
  parameter int unsigned PASS_W = 8
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [ROW_W-1:0]  cmd_rows;
  logic [PASS_W-1:0] cmd_passes;
  logic              mmu_go;
  logic              mmu_valid;
  logic              acc_enable;
  logic              acc_sel;
  logic              rd_valid;
  logic              rd_buf;
  logic              rd_done;

  modport master (
    input  cmd_valid, cmd_rows, cmd_passes, mmu_valid, rd_done,
    output cmd_ready, mmu_go, acc_enable, acc_sel, rd_valid, rd_buf
  );

  modport slave (
    output cmd_valid, cmd_rows, cmd_passes, mmu_valid, rd_done,
    input  cmd_ready, mmu_go, acc_enable, acc_sel, rd_valid, rd_buf
  );
endinterface

// File: rtl/acc_sequencer.sv
// Sequences K-pass tiles into a double-buffered accumulator and hands completed buffers to a
// reader, stalling new tiles while both buffers still hold unread results.
module acc_sequencer #(
  parameter int unsigned ROW_W     = 8,
  parameter int unsigned PASS_W    = 8,
  parameter int unsigned ALIGN_LAT = 2   // must be >= 1
) (
  input  logic                  clk,
  input  logic                  reset,
  acc_sequencer_if.master       bus,
  output logic                  busy,
  output logic                  err_overrun
);

  localparam int unsigned GuardW = (ALIGN_LAT > 1) ? $clog2(ALIGN_LAT) : 1;

  typedef enum logic [2:0] {StIdle, StWaitBuf, StStream, StGuard, StPublish} state_e;

  state_e            state_q;
  logic [ROW_W-1:0]  rows_m1_q, row_cnt_q;
  logic [PASS_W-1:0] passes_m1_q, pass_cnt_q;
  logic [GuardW-1:0] guard_cnt_q;
  logic              acc_enable_q, acc_sel_q, err_q;
  logic              rd_ptr_q;
  logic [1:0]        full_q, full_d, full_set, full_clr;
  logic              rd_fire, buf_free, publish;

  assign rd_fire = bus.rd_done & full_q[rd_ptr_q];
  assign publish = (state_q == StPublish);
  // A buffer freed by this cycle's rd_done lets the waiting tile start next cycle.
  assign buf_free = ~full_q[acc_sel_q] | (rd_fire & (rd_ptr_q == acc_sel_q));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      rows_m1_q    <= '0;
      row_cnt_q    <= '0;
      passes_m1_q  <= '0;
      pass_cnt_q   <= '0;
      guard_cnt_q  <= '0;
      acc_enable_q <= 1'b0;
      acc_sel_q    <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      if (bus.mmu_valid && state_q != StStream) err_q <= 1'b1;
      case (state_q)
        StIdle: begin
          if (bus.cmd_valid) begin
            rows_m1_q    <= (bus.cmd_rows == '0) ? '0 : bus.cmd_rows - ROW_W'(1);
            passes_m1_q  <= (bus.cmd_passes == '0) ? '0 : bus.cmd_passes - PASS_W'(1);
            row_cnt_q    <= '0;
            pass_cnt_q   <= '0;
            acc_enable_q <= 1'b0;
            state_q      <= StWaitBuf;
          end
        end
        StWaitBuf: begin
          if (buf_free) state_q <= StStream;
        end
        StStream: begin
          if (bus.mmu_valid) begin
            if (row_cnt_q == rows_m1_q) begin
              row_cnt_q   <= '0;
              guard_cnt_q <= GuardW'(ALIGN_LAT - 1);
              state_q     <= StGuard;
            end else begin
              row_cnt_q <= row_cnt_q + ROW_W'(1);
            end
          end
        end
        StGuard: begin
          if (guard_cnt_q == '0) begin
            if (pass_cnt_q == passes_m1_q) begin
              state_q <= StPublish;
            end else begin
              pass_cnt_q   <= pass_cnt_q + PASS_W'(1);
              acc_enable_q <= 1'b1;
              state_q      <= StStream;
            end
          end else begin
            guard_cnt_q <= guard_cnt_q - GuardW'(1);
          end
        end
        StPublish: begin
          acc_sel_q    <= ~acc_sel_q;
          acc_enable_q <= 1'b0;
          state_q      <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Publish and read completion never target the same buffer, so both apply independently.
  always_comb begin
    full_set = 2'b00;
    full_clr = 2'b00;
    if (publish) full_set = acc_sel_q ? 2'b10 : 2'b01;
    if (rd_fire) full_clr = rd_ptr_q ? 2'b10 : 2'b01;
    full_d = (full_q & ~full_clr) | full_set;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full_q   <= 2'b00;
      rd_ptr_q <= 1'b0;
    end else begin
      full_q <= full_d;
      if (rd_fire) rd_ptr_q <= ~rd_ptr_q;
    end
  end

  assign bus.cmd_ready  = (state_q == StIdle);
  assign bus.mmu_go     = (state_q == StStream);
  assign bus.acc_enable = acc_enable_q;
  assign bus.acc_sel    = acc_sel_q;
  assign bus.rd_valid   = full_q[rd_ptr_q];
  assign bus.rd_buf     = rd_ptr_q;
  assign busy           = (state_q != StIdle);
  assign err_overrun    = err_q;

endmodule

// File: tb/tb_acc_sequencer.sv
// Directed bench for acc_sequencer: a table of continuous-beat tiles plus hand-written stall,
// publish/read collision, overrun and asynchronous-reset sequences.
module tb_acc_sequencer;

  logic clk = 1'b0;
  logic reset;
  logic busy, err_overrun;
  int   tests = 0;
  int   failed = 0;

  acc_sequencer_if #(.ROW_W(8), .PASS_W(8)) bus ();

  acc_sequencer #(.ROW_W(8), .PASS_W(8), .ALIGN_LAT(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .busy        (busy),
    .err_overrun (err_overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] rows;
    logic [7:0] passes;
    int         exp_beats;
    int         exp_lat;
    int         exp_en_beats;
    int         exp_gap;
    logic       exp_buf;
  } vec_t;

  vec_t vecs[5];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic reset_dut();
    bus.cmd_valid = 1'b0;
    bus.mmu_valid = 1'b0;
    bus.rd_done   = 1'b0;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic send_cmd(input logic [7:0] rows, input logic [7:0] passes);
    check("cmd_ready_before_cmd", bus.cmd_ready, 1);
    bus.cmd_valid  = 1'b1;
    bus.cmd_rows   = rows;
    bus.cmd_passes = passes;
    step();
    bus.cmd_valid  = 1'b0;
  endtask

  // Feeds a beat in every cycle mmu_go is high until the sequencer returns to idle.
  task automatic finish_tile(output int lat, output int beats, output int en_beats,
                             output int gap);
    int  first, last;
    bit  done;
    lat = 0; beats = 0; en_beats = 0; first = -1; last = -1; done = 1'b0;
    for (int cyc = 1; cyc < 400 && !done; cyc++) begin
      if (!busy) begin
        lat  = cyc;
        done = 1'b1;
      end else begin
        bus.mmu_valid = bus.mmu_go;
        if (bus.mmu_go) begin
          beats++;
          if (bus.acc_enable) en_beats++;
          if (first < 0) first = cyc;
          last = cyc;
        end
        step();
      end
    end
    bus.mmu_valid = 1'b0;
    check("tile_completes", done, 1);
    gap = (first < 0) ? 0 : last - first + 1 - beats;
  endtask

  task automatic pulse_rd_done();
    bus.rd_done = 1'b1;
    step();
    bus.rd_done = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  lat, beats, en_beats, gap;
    bit  saw_go;

    vecs[0] = '{rows: 8'd4, passes: 8'd1, exp_beats: 4,  exp_lat: 9,  exp_en_beats: 0,
                exp_gap: 0, exp_buf: 1'b0};
    vecs[1] = '{rows: 8'd3, passes: 8'd3, exp_beats: 9,  exp_lat: 18, exp_en_beats: 6,
                exp_gap: 4, exp_buf: 1'b1};
    vecs[2] = '{rows: 8'd0, passes: 8'd0, exp_beats: 1,  exp_lat: 6,  exp_en_beats: 0,
                exp_gap: 0, exp_buf: 1'b0};
    vecs[3] = '{rows: 8'd1, passes: 8'd2, exp_beats: 2,  exp_lat: 9,  exp_en_beats: 1,
                exp_gap: 2, exp_buf: 1'b1};
    vecs[4] = '{rows: 8'd5, passes: 8'd2, exp_beats: 10, exp_lat: 17, exp_en_beats: 5,
                exp_gap: 2, exp_buf: 1'b0};

    // Reset values while reset is held, before any clock edge.
    bus.cmd_valid = 1'b0; bus.cmd_rows = '0; bus.cmd_passes = '0;
    bus.mmu_valid = 1'b0; bus.rd_done = 1'b0;
    reset = 1'b1;
    #2;
    check("rst_cmd_ready", bus.cmd_ready, 1);
    check("rst_mmu_go", bus.mmu_go, 0);
    check("rst_acc_enable", bus.acc_enable, 0);
    check("rst_acc_sel", bus.acc_sel, 0);
    check("rst_rd_valid", bus.rd_valid, 0);
    check("rst_rd_buf", bus.rd_buf, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err_overrun, 0);
    reset_dut();

    // Table: one tile per vector, drained after checking.
    foreach (vecs[i]) begin
      send_cmd(vecs[i].rows, vecs[i].passes);
      check("wait_buf_no_go", bus.mmu_go, 0);
      finish_tile(lat, beats, en_beats, gap);
      check("tile_latency", lat, vecs[i].exp_lat);
      check("tile_beats", beats, vecs[i].exp_beats);
      check("tile_accum_beats", en_beats, vecs[i].exp_en_beats);
      check("tile_gap_cycles", gap, vecs[i].exp_gap);
      check("tile_rd_valid", bus.rd_valid, 1);
      check("tile_rd_buf", bus.rd_buf, vecs[i].exp_buf);
      check("tile_acc_sel", bus.acc_sel, !vecs[i].exp_buf);
      check("tile_acc_enable_idle", bus.acc_enable, 0);
      pulse_rd_done();
      check("drain_rd_valid", bus.rd_valid, 0);
    end
    check("no_overrun_yet", err_overrun, 0);

    // Three tiles without reads: third one stalls until a buffer is freed.
    reset_dut();
    send_cmd(8'd2, 8'd1);
    finish_tile(lat, beats, en_beats, gap);
    check("t0_rd_buf", bus.rd_buf, 0);
    check("t0_acc_sel", bus.acc_sel, 1);
    send_cmd(8'd2, 8'd1);
    finish_tile(lat, beats, en_beats, gap);
    check("t1_latency", lat, 7);
    check("t1_rd_buf_oldest", bus.rd_buf, 0);
    check("t1_acc_sel", bus.acc_sel, 0);
    send_cmd(8'd2, 8'd1);
    saw_go = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (bus.mmu_go || !busy) saw_go = 1'b1;
      step();
    end
    check("t2_stalled", saw_go, 0);
    check("t2_stall_rd_valid", bus.rd_valid, 1);
    bus.rd_done = 1'b1;
    step();
    bus.rd_done = 1'b0;
    check("t2_stream_after_free", bus.mmu_go, 1);
    check("t2_rd_buf_toggled", bus.rd_buf, 1);
    check("t2_rd_valid", bus.rd_valid, 1);
    check("t2_writes_buf0", bus.acc_sel, 0);
    finish_tile(lat, beats, en_beats, gap);
    check("t2_beats", beats, 2);
    check("t2_rd_buf", bus.rd_buf, 1);
    check("t2_acc_sel", bus.acc_sel, 1);

    // Free buffer 1 so only buffer 0 is full, then collide publish of buffer 1 with rd_done.
    pulse_rd_done();
    check("pre_collide_rd_buf", bus.rd_buf, 0);
    check("pre_collide_rd_valid", bus.rd_valid, 1);
    send_cmd(8'd1, 8'd1);                 // cycle 1: WAIT_BUF
    step();                               // cycle 2: STREAM
    check("col_stream", bus.mmu_go, 1);
    bus.mmu_valid = 1'b1;
    step();                               // cycle 3: GUARD
    bus.mmu_valid = 1'b0;
    check("col_guard", bus.mmu_go, 0);
    step();                               // cycle 4: GUARD
    step();                               // cycle 5: PUBLISH
    check("col_publish_busy", busy, 1);
    bus.rd_done = 1'b1;
    step();
    bus.rd_done = 1'b0;
    check("col_idle", busy, 0);
    check("col_rd_valid", bus.rd_valid, 1);
    check("col_rd_buf", bus.rd_buf, 1);
    check("col_acc_sel", bus.acc_sel, 0);
    pulse_rd_done();
    check("col_drained", bus.rd_valid, 0);
    pulse_rd_done();
    check("ignored_rd_done_ptr", bus.rd_buf, 0);
    check("ignored_rd_done_valid", bus.rd_valid, 0);

    // Beat while idle sets a sticky error.
    bus.mmu_valid = 1'b1;
    step();
    bus.mmu_valid = 1'b0;
    check("overrun_set", err_overrun, 1);
    step(); step(); step();
    check("overrun_sticky", err_overrun, 1);
    check("overrun_idle", busy, 0);

    // Publish buffer 0, then reset asynchronously in the middle of the second pass.
    send_cmd(8'd1, 8'd1);
    finish_tile(lat, beats, en_beats, gap);
    check("pre_rst_rd_valid", bus.rd_valid, 1);
    send_cmd(8'd2, 8'd2);
    saw_go = 1'b0;
    for (int k = 0; k < 20 && !saw_go; k++) begin
      if (bus.mmu_go && bus.acc_enable) begin
        saw_go = 1'b1;
      end else begin
        bus.mmu_valid = bus.mmu_go;
        step();
      end
    end
    bus.mmu_valid = 1'b0;
    check("reached_pass1", saw_go, 1);
    #3;
    reset = 1'b1;
    #1;
    check("arst_cmd_ready", bus.cmd_ready, 1);
    check("arst_mmu_go", bus.mmu_go, 0);
    check("arst_acc_enable", bus.acc_enable, 0);
    check("arst_acc_sel", bus.acc_sel, 0);
    check("arst_rd_valid", bus.rd_valid, 0);
    check("arst_rd_buf", bus.rd_buf, 0);
    check("arst_busy", busy, 0);
    check("arst_err", err_overrun, 0);
    step(); step();
    reset = 1'b0;
    step();
    send_cmd(8'd2, 8'd1);
    finish_tile(lat, beats, en_beats, gap);
    check("post_rst_latency", lat, 7);
    check("post_rst_rd_buf", bus.rd_buf, 0);
    check("post_rst_rd_valid", bus.rd_valid, 1);
    check("post_rst_acc_sel", bus.acc_sel, 1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
